// File: rtl/controlador_perifericos_pkg.sv
// Shared register offsets and bit positions for the peripheral controller.
package controlador_perifericos_pkg;

    // Register offsets within the 8-byte window (5-7 are unmapped)
    typedef enum logic [2:0] {
        OFS_OUT    = 3'd0,
        OFS_IN     = 3'd1,
        OFS_RELOAD = 3'd2,
        OFS_CTRL   = 3'd3,
        OFS_PEND   = 3'd4
    } ofs_e;

    // CTRL register fields
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MASK_LSB = 1;
    localparam int CTRL_W        = 4;

    // PEND register fields
    localparam int PEND_TMR = 0;
    localparam int PEND_PB0 = 1;
    localparam int PEND_PB1 = 2;
    localparam int PEND_W   = 3;

endpackage

// File: rtl/controlador_perifericos_if.sv
// CPU-side memory-mapped bus plus interrupt request lines.
interface controlador_perifericos_if;
    import controlador_perifericos_pkg::*;

    logic              rd;
    logic              wr;
    logic [15:0]       dir;
    logic [7:0]        datos_cpu;
    logic [7:0]        datos_a_cpu;
    logic [PEND_W-1:0] interrupciones;

    modport master (
        output rd, wr, dir, datos_cpu,
        input  datos_a_cpu, interrupciones
    );

    modport slave (
        input  rd, wr, dir, datos_cpu,
        output datos_a_cpu, interrupciones
    );

endinterface

// File: rtl/controlador_perifericos_sincronizador_flanco.sv
// Two-flop synchronizer for one asynchronous input, with an optional delay flop
// that turns the synchronized level into a one-cycle rising-edge pulse.
module sincronizador_flanco #(
    parameter bit CON_FLANCO = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic nivel,
    output logic flanco
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Next values: shift the pin through the synchronizer and the delay stage
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = CON_FLANCO ? s2_q : 1'b0;
    end

    // Synchronizer and delay registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign nivel  = s2_q;
    assign flanco = CON_FLANCO ? (s2_q & ~prev_q) : 1'b0;

endmodule

// File: rtl/controlador_perifericos.sv
// Memory-mapped I/O responder: output port, synchronized input port,
// reloadable interval timer and two push-button edge interrupts.
module controlador_perifericos
    import controlador_perifericos_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter int          PRESCALER = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    controlador_perifericos_if.slave      bus,
    input  logic [7:0]                    interruptores,
    input  logic [1:0]                    pulsadores,
    output logic [7:0]                    leds
);

    localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;

    logic [7:0]        out_q, out_d;
    logic [7:0]        reload_q, reload_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PW-1:0]     presc_q, presc_d;

    logic [7:0]        sw_sync;
    logic [7:0]        sw_flanco_unused;
    logic [1:0]        pb_flanco;
    logic [1:0]        pb_nivel_unused;

    logic              hit;
    logic [2:0]        ofs;
    logic              we;
    logic              reload_we;
    logic              tick;
    logic              tmr_set;
    logic [PEND_W-1:0] pend_clr;

    for (genvar i = 0; i < 8; i++) begin : g_sw
        sincronizador_flanco #(.CON_FLANCO(1'b0)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .d      (interruptores[i]),
            .nivel  (sw_sync[i]),
            .flanco (sw_flanco_unused[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_pb
        sincronizador_flanco #(.CON_FLANCO(1'b1)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .d      (pulsadores[i]),
            .nivel  (pb_nivel_unused[i]),
            .flanco (pb_flanco[i])
        );
    end

    assign hit       = (bus.dir[15:3] == BASE[15:3]);
    assign ofs       = bus.dir[2:0];
    assign we        = bus.wr & hit;
    assign reload_we = we & (ofs == OFS_RELOAD);

    // Register-file, timer and pending-bit next-state logic
    always_comb begin
        out_d    = out_q;
        reload_d = reload_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        tick     = 1'b0;
        tmr_set  = 1'b0;
        pend_clr = '0;

        // A RELOAD write restarts the timer and discards any tick on that edge
        if (ctrl_q[CTRL_EN] && !reload_we) begin
            if (presc_q == PW'(PRESCALER - 1)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (tick) begin
            if (cnt_q == 8'd0 && reload_q != 8'd0) begin
                tmr_set = 1'b1;
                cnt_d   = reload_q - 8'd1;
            end else if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        if (we) begin
            case (ofs)
                OFS_OUT:    out_d = bus.datos_cpu;
                OFS_RELOAD: begin
                    reload_d = bus.datos_cpu;
                    cnt_d    = (bus.datos_cpu == 8'd0) ? 8'd0 : bus.datos_cpu - 8'd1;
                    presc_d  = '0;
                end
                OFS_CTRL:   ctrl_d   = bus.datos_cpu[CTRL_W-1:0];
                OFS_PEND:   pend_clr = bus.datos_cpu[PEND_W-1:0];
                default:    ;
            endcase
        end

        pend_d = pend_q & ~pend_clr;
        pend_d[PEND_TMR] = pend_d[PEND_TMR] | tmr_set;
        pend_d[PEND_PB0] = pend_d[PEND_PB0] | pb_flanco[0];
        pend_d[PEND_PB1] = pend_d[PEND_PB1] | pb_flanco[1];
    end

    // State registers; reset overrides any bus write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            reload_q <= '0;
            ctrl_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            presc_q  <= '0;
        end else begin
            out_q    <= out_d;
            reload_q <= reload_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
        end
    end

    // Combinational read mux
    always_comb begin
        bus.datos_a_cpu = '0;
        if (bus.rd && hit) begin
            case (ofs)
                OFS_OUT:    bus.datos_a_cpu = out_q;
                OFS_IN:     bus.datos_a_cpu = sw_sync;
                OFS_RELOAD: bus.datos_a_cpu = reload_q;
                OFS_CTRL:   bus.datos_a_cpu = {4'b0000, ctrl_q};
                OFS_PEND:   bus.datos_a_cpu = {5'b00000, pend_q};
                default:    bus.datos_a_cpu = '0;
            endcase
        end
    end

    assign bus.interrupciones = pend_q & ctrl_q[CTRL_MASK_LSB +: PEND_W];
    assign leds               = out_q;

endmodule

// File: tb/tb_controlador_perifericos.sv
// Directed plus randomized bench for controlador_perifericos against a
// register-level reference model.
module tb_controlador_perifericos;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          P    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [1:0] pb;
    logic [7:0] leds;

    always #5 clk = ~clk;

    controlador_perifericos_if bif();

    controlador_perifericos #(.BASE(BASE), .PRESCALER(P)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bif),
        .interruptores (sw),
        .pulsadores    (pb),
        .leds          (leds)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: architectural registers, enabled-cycle count since the
    // last timer restart, and pin samples taken at past clock edges.
    logic [7:0] m_out    = '0;
    logic [7:0] m_reload = '0;
    logic [3:0] m_ctrl   = '0;
    logic [2:0] m_pend   = '0;
    int         m_en     = 0;
    logic [7:0] m_sw0 = '0, m_sw1 = '0;
    logic [1:0] m_pb0 = '0, m_pb1 = '0, m_pb2 = '0;

    function automatic logic [7:0] m_read(input logic r, input logic [15:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (r && a[15:3] == BASE[15:3]) begin
            case (a[2:0])
                3'd0: v = m_out;
                3'd1: v = m_sw1;
                3'd2: v = m_reload;
                3'd3: v = {4'h0, m_ctrl};
                3'd4: v = {5'h00, m_pend};
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic       we;
        logic       tset;
        logic [2:0] np;
        if (reset) begin
            m_out = '0; m_reload = '0; m_ctrl = '0; m_pend = '0; m_en = 0;
            m_sw0 = '0; m_sw1 = '0; m_pb0 = '0; m_pb1 = '0; m_pb2 = '0;
        end else begin
            we   = w && (a[15:3] == BASE[15:3]);
            tset = 1'b0;
            // Interrupt every P*RELOAD enabled cycles after the last RELOAD write
            if (we && a[2:0] == 3'd2) begin
                m_en = 0;
            end else if (m_ctrl[0]) begin
                m_en++;
                if (m_reload != 0 && (m_en % (P * int'(m_reload))) == 0) tset = 1'b1;
            end
            np = m_pend;
            if (we && a[2:0] == 3'd4) np = np & ~d[2:0];
            np = np | {m_pb1[1] & ~m_pb2[1], m_pb1[0] & ~m_pb2[0], tset};
            m_pend = np;
            if (we && a[2:0] == 3'd0) m_out = d;
            if (we && a[2:0] == 3'd2) m_reload = d;
            if (we && a[2:0] == 3'd3) m_ctrl = d[3:0];
            m_sw1 = m_sw0; m_sw0 = sw;
            m_pb2 = m_pb1; m_pb1 = m_pb0; m_pb0 = pb;
        end
    endtask

    // One bus cycle: check the combinational read, clock, then check outputs
    task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        bif.rd = r; bif.wr = w; bif.dir = a; bif.datos_cpu = d;
        #1;
        check("rdata", bif.datos_a_cpu, m_read(r, a));
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check("leds", leds, m_out);
        check("irq", {5'h00, bif.interrupciones}, {5'h00, m_pend & m_ctrl[3:1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic rd_const(input string tag, input logic [15:0] a, input logic [7:0] exp);
        bif.rd = 1'b1; bif.wr = 1'b0; bif.dir = a; bif.datos_cpu = 8'h00;
        #1;
        check(tag, bif.datos_a_cpu, exp);
        cyc(1'b1, 1'b0, a, 8'h00);
    endtask

    initial begin
        reset = 1'b1; sw = '0; pb = '0;
        bif.rd = 1'b0; bif.wr = 1'b0; bif.dir = '0; bif.datos_cpu = '0;
        idle(2);
        check("rst_leds", leds, 8'h00);
        check("rst_irq", {5'h00, bif.interrupciones}, 8'h00);
        check("rst_rdata", bif.datos_a_cpu, 8'h00);
        reset = 1'b0;

        // Output port and decode
        cyc(1'b0, 1'b1, BASE, 8'hA5);
        check("leds_a5", leds, 8'hA5);
        rd_const("rd_out", BASE, 8'hA5);
        rd_const("rd_ofs6", BASE + 16'd6, 8'h00);
        rd_const("rd_miss", 16'h0000, 8'h00);

        // Synchronized input port, read-only
        sw = 8'h3C;
        idle(2);
        rd_const("rd_in", BASE + 16'd1, 8'h3C);
        cyc(1'b0, 1'b1, BASE + 16'd1, 8'hFF);
        rd_const("in_ro", BASE + 16'd1, 8'h3C);

        // Timer: 4 clk/tick, reload 3 -> interrupt every 12 enabled cycles
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h03);
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h03);
        idle(11);
        check("irq_before12", {5'h00, bif.interrupciones}, 8'h00);
        idle(1);
        check("irq_at12", {5'h00, bif.interrupciones}, 8'h01);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h01);
        check("irq_cleared", {5'h00, bif.interrupciones}, 8'h00);
        idle(11);
        check("irq_at24", {5'h00, bif.interrupciones}, 8'h01);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h01);
        idle(10);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h01);
        rd_const("set_wins", BASE + 16'd4, 8'h01);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h00);
        rd_const("w0_noop", BASE + 16'd4, 8'h01);

        // Button edge latches while masked, line asserts once unmasked
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h02);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h07);
        pb = 2'b10;
        idle(5);
        pb = 2'b00;
        idle(3);
        rd_const("pb_pend", BASE + 16'd4, 8'h04);
        check("pb_masked", {5'h00, bif.interrupciones}, 8'h00);
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h08);
        check("pb_unmasked", {5'h00, bif.interrupciones}, 8'h04);

        // Reset in the middle of a timer count
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h02);
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h03);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h07);
        idle(5);
        reset = 1'b1;
        cyc(1'b0, 1'b1, BASE, 8'h5A);
        reset = 1'b0;
        check("rst_mid_leds", leds, 8'h00);
        rd_const("rst_reload", BASE + 16'd2, 8'h00);
        rd_const("rst_ctrl", BASE + 16'd3, 8'h00);
        rd_const("rst_pend", BASE + 16'd4, 8'h00);
        idle(30);
        check("rst_no_irq", {5'h00, bif.interrupciones}, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic        r, w;
            logic [15:0] a;
            logic [7:0]  d;
            reset = ($urandom_range(0, 199) == 0);
            sw    = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pb = 2'($urandom);
            r = 1'($urandom);
            w = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 4) != 0) ? (BASE | 16'($urandom_range(0, 7))) : 16'($urandom);
            d = 8'($urandom);
            if (a[2:0] == 3'd2) d = 8'($urandom_range(0, 3));
            if (a[2:0] == 3'd3) d[0] = ($urandom_range(0, 3) != 0);
            cyc(r, w, a, d);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
